// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-Lite slave to multi-slave APB master bridge with address decode,
// pready wait states, pslverr/decode-miss/timeout ERROR responses.
module ahb2apb_bridge_mslv #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned SLV_SEL_LSB = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h4000_0000,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [DATA_W-1:0]         hwdata,
  input  logic                      hready_in,
  output logic                      hready_out,
  output logic                      hresp,
  output logic [DATA_W-1:0]         hrdata,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int unsigned SEL_W = $clog2(NUM_SLV);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TAG_LSB = SLV_SEL_LSB + SEL_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   hrdata_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pwrite_q;

  logic                accept_st, accept, hit, take;
  logic [SEL_W-1:0]    haddr_idx;
  logic                sel_ready, sel_err, tmo;

  assign accept_st = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign accept    = accept_st & hsel & htrans[1] & hready_in;
  assign haddr_idx = haddr[SLV_SEL_LSB +: SEL_W];
  // A tag match alone is not enough when NUM_SLV is not a power of two.
  assign hit       = (haddr[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]) &&
                     (32'(haddr_idx) < NUM_SLV);
  assign take      = accept & hit;
  assign sel_ready = pready[idx_q];
  assign sel_err   = pslverr[idx_q];
  assign tmo       = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          if (!hit)        state_d = S_ERR1;
          else if (hwrite) state_d = S_WDATA;
          else             state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready) state_d = sel_err ? S_ERR1 : S_DONE;
        else if (tmo)  state_d = S_ERR1;
      end
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hready_out = 1'b1;
    hresp      = 1'b0;
    psel       = '0;
    penable    = 1'b0;
    unique case (state_q)
      S_WDATA:  hready_out = 1'b0;
      S_SETUP: begin
        hready_out = 1'b0;
        psel[idx_q] = 1'b1;
      end
      S_ACCESS: begin
        hready_out = 1'b0;
        psel[idx_q] = 1'b1;
        penable    = 1'b1;
      end
      S_ERR1: begin
        hready_out = 1'b0;
        hresp      = 1'b1;
      end
      S_ERR2:   hresp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      hrdata_q <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      if (take) begin
        idx_q    <= haddr_idx;
        paddr_q  <= haddr;
        pwrite_q <= hwrite;
      end
      if (state_q == S_WDATA) pwdata_q <= hwdata;
      if (state_q == S_ACCESS) cnt_q <= cnt_q + 1'b1;
      else                     cnt_q <= '0;
      if ((state_q == S_ACCESS) && sel_ready && !sel_err && !pwrite_q)
        hrdata_q <= prdata[32'(idx_q)*DATA_W +: DATA_W];
    end
  end

  assign hrdata = hrdata_q;
  assign paddr  = paddr_q;
  assign pwdata = pwdata_q;
  assign pwrite = pwrite_q;

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
// Directed bench for ahb2apb_bridge_mslv; expected responses queued at drive
// time and compared when the bridge raises hready_out.
module tb_ahb2apb_bridge_mslv;

  logic         hclk = 1'b0;
  logic         hreset, hsel, hwrite, hready_in;
  logic [1:0]   htrans;
  logic [31:0]  haddr, hwdata;
  logic         hready_out, hresp, penable, pwrite;
  logic [31:0]  hrdata, paddr, pwdata;
  logic [3:0]   psel, pready, pslverr;
  logic [127:0] prdata;

  typedef struct packed {
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 hclk = ~hclk;

  ahb2apb_bridge_mslv #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_SEL_LSB(12),
    .BASE_ADDR(32'h4000_0000), .TIMEOUT(16)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans),
    .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hready_in(hready_in),
    .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                      input int unsigned slv, input int unsigned waits, input logic perr,
                      input logic exp_resp, input int unsigned exp_low,
                      input int unsigned exp_pen, input logic [3:0] exp_psel,
                      input string tag);
    exp_t        e, got;
    logic [3:0]  oh;
    logic [3:0]  seen = '0;
    logic        resp_low = 1'b0;
    bit          done = 0;
    int unsigned low = 0, pen = 0, left = waits;
    oh = 4'b0001 << slv;
    e.resp  = exp_resp;
    e.rdata = (!wr && !exp_resp) ? prdata[slv*32 +: 32] : last_rd;
    last_rd = e.rdata;
    sb.push_back(e);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge hclk);
      if (c == 0) begin
        hsel = 1'b0; htrans = 2'b00; hwdata = wdat;
      end
      if (hready_out) begin
        done = 1;
      end else begin
        low++;
        resp_low = hresp;
        if (psel != '0) seen = psel;
        if (penable) begin
          pen++;
          if (left > 0) begin
            left--;
            pready = ~oh; pslverr = ~oh;
          end else begin
            pready = oh; pslverr = perr ? oh : ~oh;
          end
        end else begin
          pready = ~oh; pslverr = ~oh;
        end
      end
    end
    pready = ~oh; pslverr = ~oh;
    check({tag, "_completed"}, 64'(done), 64'd1);
    check({tag, "_low_cycles"}, 64'(low), 64'(exp_low));
    check({tag, "_penable_cycles"}, 64'(pen), 64'(exp_pen));
    check({tag, "_psel"}, 64'(seen), 64'(exp_psel));
    if (exp_resp) check({tag, "_err1_hresp"}, 64'(resp_low), 64'd1);
    got = sb.pop_front();
    check({tag, "_hresp"}, 64'(hresp), 64'(got.resp));
    check({tag, "_hrdata"}, 64'(hrdata), 64'(got.rdata));
    if (exp_psel != '0) begin
      check({tag, "_paddr"}, 64'(paddr), 64'(addr));
      check({tag, "_pwrite"}, 64'(pwrite), 64'(wr));
    end
    if (wr && !exp_resp) check({tag, "_pwdata"}, 64'(pwdata), 64'(wdat));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hready_out"}, 64'(hready_out), 64'd1);
    check({tag, "_hresp"}, 64'(hresp), 64'd0);
    check({tag, "_psel"}, 64'(psel), 64'd0);
    check({tag, "_penable"}, 64'(penable), 64'd0);
    check({tag, "_pwrite"}, 64'(pwrite), 64'd0);
    check({tag, "_paddr"}, 64'(paddr), 64'd0);
    check({tag, "_pwdata"}, 64'(pwdata), 64'd0);
    check({tag, "_hrdata"}, 64'(hrdata), 64'd0);
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    haddr = '0; hwdata = '0; hready_in = 1'b1;
    pready = '0; pslverr = '0;
    prdata = {32'd33, 32'd22, 32'd30, 32'd11};
    last_rd = '0;
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    check_reset_outputs("reset");

    // IDLE-type transfer: zero-wait OKAY and no APB activity
    hsel = 1'b1; htrans = 2'b00; haddr = 32'h4000_1000;
    @(negedge hclk);
    check("idle_hready", 64'(hready_out), 64'd1);
    check("idle_psel", 64'(psel), 64'd0);
    hsel = 1'b0;
    @(negedge hclk);

    xfer(1'b1, 32'h4000_2008, 32'd34, 2, 0, 1'b0, 1'b0, 3, 1, 4'b0100, "wr_s2");
    @(negedge hclk);
    xfer(1'b0, 32'h4000_1000, 32'd0, 1, 2, 1'b0, 1'b0, 4, 3, 4'b0010, "rd_s1_wait2");
    @(negedge hclk);
    xfer(1'b1, 32'h4000_3004, 32'h77, 3, 0, 1'b1, 1'b1, 4, 1, 4'b1000, "wr_s3_slverr");
    @(negedge hclk);
    check("pwdata_after_err", 64'(pwdata), 64'h77);
    xfer(1'b0, 32'h4000_3000, 32'd0, 3, 0, 1'b0, 1'b0, 2, 1, 4'b1000, "rd_s3_after_err");
    @(negedge hclk);
    xfer(1'b0, 32'h5000_0000, 32'd0, 0, 0, 1'b0, 1'b1, 1, 0, 4'b0000, "decode_miss");
    check("miss_paddr_held", 64'(paddr), 64'h4000_3000);
    @(negedge hclk);
    xfer(1'b0, 32'h4000_0000, 32'd0, 0, 100, 1'b0, 1'b1, 18, 16, 4'b0001, "timeout");
    @(negedge hclk);

    // back-to-back: second accepted during DONE of the first
    xfer(1'b0, 32'h4000_0000, 32'd0, 0, 0, 1'b0, 1'b0, 2, 1, 4'b0001, "b2b_rd_s0");
    xfer(1'b1, 32'h4000_2010, 32'h55, 2, 0, 1'b0, 1'b0, 3, 1, 4'b0100, "b2b_wr_s2");
    @(negedge hclk);

    // reset asserted mid-ACCESS
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h4000_1000;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; pready = '0;
    @(negedge hclk);
    check("pre_reset_penable", 64'(penable), 64'd1);
    hreset = 1'b1;
    @(negedge hclk);
    check_reset_outputs("mid_access_reset");
    @(negedge hclk);
    hreset = 1'b0;
    pready = 4'b1101;
    @(negedge hclk);
    check("post_reset_hready", 64'(hready_out), 64'd1);
    check("post_reset_psel", 64'(psel), 64'd0);
    last_rd = '0;
    xfer(1'b0, 32'h4000_2000, 32'd0, 2, 1, 1'b0, 1'b0, 3, 2, 4'b0100, "rd_s2_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
